uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with start-bit validation and a small receive FIFO
// Received bytes are queued for a valid/ready consumer; framing errors and overruns pulse for one cycle.
module uart_rx #(
  parameter int BAUD_2_CLOCK_RATIO = 1250,
  parameter int UART_DATA_BITS     = 8,
  parameter int UART_STOP_BITS     = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int CW = $clog2(BAUD_2_CLOCK_RATIO);
  localparam int HALF = BAUD_2_CLOCK_RATIO / 2;
  localparam int BW = 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LOAD = CW'(BAUD_2_CLOCK_RATIO - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(UART_DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(UART_STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t state_q, state_d;
  logic rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] sr_q, sr_d;
  logic stop_ok_q, stop_ok_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic tick, push_req, push_ok, pop, full, empty;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    stop_ok_d = stop_ok_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = BIT_LOAD;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sr_d  = {rx_s_q, sr_q[UART_DATA_BITS-1:1]};
          cnt_d = BIT_LOAD;
          if (bit_q == LAST_DATA) begin
            state_d   = STOP;
            bit_d     = '0;
            stop_ok_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = BIT_LOAD;
          // Verdict is deferred to the last stop sample so every outcome lands on the same cycle.
          if (bit_q == LAST_STOP) begin
            if (stop_ok_q && rx_s_q) begin
              push_req = 1'b1;
              state_d  = IDLE;
            end else begin
              frame_err = 1'b1;
              state_d   = WAIT_IDLE;
            end
          end else begin
            bit_d     = bit_q + 1'b1;
            stop_ok_d = stop_ok_q & rx_s_q;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid   = !empty;
  assign pop     = valid && ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign push_ok = push_req && (!full || pop);
  assign overrun = push_req && full && !pop;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign data    = mem_q[rd_ptr_q[AW-1:0]];
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= rx_s_q ? IDLE : WAIT_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      stop_ok_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      stop_ok_q <= stop_ok_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= sr_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
// Drives serial frames bit by bit and checks received bytes, flags and timing against hand-computed values.
module tb_uart_rx;

  localparam int B  = 41;
  localparam int H  = B / 2;
  localparam int DB = 8;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx = 1'b1;
  logic ready = 1'b0;
  logic [DB-1:0] data;
  logic valid, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx #(
    .BAUD_2_CLOCK_RATIO(B),
    .UART_DATA_BITS(DB),
    .UART_STOP_BITS(SB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx(rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vld_cnt = 0;
  int rise_cyc = -1;
  logic vld_prev = 1'b0;
  logic [DB-1:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (valid) vld_cnt <= vld_cnt + 1;
    if (valid && !vld_prev) rise_cyc <= cyc;
    vld_prev <= valid;
    if (valid && ready) got_q.push_back(data);
  end

  int n_chk = 0;
  int n_err = 0;
  int got_rd = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic expect_byte(input string name, input int exp);
    if (got_rd < got_q.size()) begin
      check(name, int'(got_q[got_rd]), exp);
      got_rd++;
    end else begin
      check(name, -1, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick(B);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic bad_stop2);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(b[i]);
    send_bit(1'b1);
    send_bit(!bad_stop2);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [DB-1:0] b;
    logic          bad;
    int            exp_n;
    logic [DB-1:0] exp_d;
    int            exp_fe;
  } vec_t;

  vec_t vecs[6];
  int c0, fe0, ov0, vl0, gn0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b1, 0, 8'h00, 1};
    vecs[2] = '{8'h11, 1'b0, 1, 8'h11, 0};
    vecs[3] = '{8'h00, 1'b0, 1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b0, 1, 8'hFF, 0};
    vecs[5] = '{8'h80, 1'b1, 0, 8'h00, 1};

    tick(5);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    resetn = 1'b1;
    tick(3);

    ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt; ov0 = ov_cnt; vl0 = vld_cnt; gn0 = got_q.size();
      c0 = cyc;
      send_frame(vecs[v].b, vecs[v].bad);
      tick(3);
      check($sformatf("vec%0d_bytes", v), got_q.size() - gn0, vecs[v].exp_n);
      check($sformatf("vec%0d_frame_err", v), fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), ov_cnt - ov0, 0);
      check($sformatf("vec%0d_valid_cycles", v), vld_cnt - vl0, vecs[v].exp_n);
      if (vecs[v].exp_n == 1) begin
        expect_byte($sformatf("vec%0d_data", v), int'(vecs[v].exp_d));
        check($sformatf("vec%0d_valid_time", v), rise_cyc - c0, 3 + H + 10 * B);
      end
    end

    fe0 = fe_cnt; gn0 = got_q.size();
    rx = 1'b0;
    tick(3);
    check("glitch_busy_rise", int'(busy), 1);
    tick(6);
    rx = 1'b1;
    tick(H - 6);
    check("glitch_busy_drop", int'(busy), 0);
    tick(2 * B);
    check("glitch_no_byte", got_q.size() - gn0, 0);
    check("glitch_no_flag", fe_cnt - fe0, 0);

    ready = 1'b0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b0);
      if (k == 4) check("ovr_none_before_5", ov_cnt - ov0, 0);
    end
    tick(3);
    check("ovr_pulse_once", ov_cnt - ov0, 1);
    check("ovr_no_frame_err", fe_cnt - fe0, 0);
    check("ovr_valid_held", int'(valid), 1);
    ready = 1'b1;
    tick(8);
    check("ovr_drain_count", got_q.size() - got_rd, 4);
    for (int k = 1; k <= 4; k++) expect_byte($sformatf("ovr_drain_%0d", k), k);
    check("ovr_empty_after", int'(valid), 0);

    ready = 1'b0;
    ov0 = ov_cnt;
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0);
    c0 = cyc;
    fork
      send_frame(8'h05, 1'b0);
      begin
        tick(2 + H + 10 * B);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(3);
    check("full_pop_no_overrun", ov_cnt - ov0, 0);
    ready = 1'b1;
    tick(10);
    check("full_drain_count", got_q.size() - got_rd, 5);
    for (int k = 1; k <= 5; k++) expect_byte($sformatf("full_drain_%0d", k), k);

    ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    tick(3);
    check("rst_fifo_loaded", int'(valid), 1);
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(((8'h77 >> i) & 8'h01) != 0);
    rx = 1'b0;
    tick(30);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check("rst_valid_cleared", int'(valid), 0);
    fe0 = fe_cnt; ov0 = ov_cnt; vl0 = vld_cnt;
    tick(B - 31);
    send_bit(1'b1);
    send_bit(1'b1);
    check("rst_no_frame_err", fe_cnt - fe0, 0);
    check("rst_no_overrun", ov_cnt - ov0, 0);
    check("rst_no_valid", vld_cnt - vl0, 0);
    check("rst_busy_low", int'(busy), 0);
    gn0 = got_q.size();
    ready = 1'b1;
    send_frame(8'h88, 1'b0);
    tick(3);
    check("rst_next_count", got_q.size() - gn0, 1);
    expect_byte("rst_next_data", 8'h88);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
